// File: rtl/insumo_magazine.sv
// Consumable magazine: CH independent level counters, each with a NORMAL/REQ/HOLD refill FSM.
// Optional per-channel consumed-unit statistics are enabled by defining MAGAZINE_STATS_EN.
module insumo_magazine #(
    parameter int CH          = 2,
    parameter int W           = 5,
    parameter int MAX_LVL     = 31,
    parameter int INIT_LVL    = 16,
    parameter int MIN_LVL     = 5,
    parameter int REFILL_QTY  = 15,
    parameter int TIMEOUT_CYC = 1000
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start_proc,
    input  logic [CH-1:0]   dec,
    input  logic [CH-1:0]   add_manual,
    input  logic [CH-1:0]   refill_ack,
    output logic [CH*W-1:0] level,
    output logic [CH-1:0]   avail,
    output logic [CH-1:0]   refill_req,
    output logic [CH-1:0]   underflow,
    output logic [CH-1:0]   fault,
    output logic [CH*16-1:0] used_total
);

    typedef enum logic [1:0] {ST_NORMAL, ST_REQ, ST_HOLD} state_t;

    // Sum is formed two bits wider than a level so it can go negative or past MAX_LVL before clamping.
    localparam int                     NW        = W + 2;
    localparam logic signed [NW-1:0]   QTY_S     = NW'(REFILL_QTY);
    localparam logic signed [NW-1:0]   ONE_S     = NW'(1);
    localparam logic signed [NW-1:0]   MAX_S     = NW'(MAX_LVL);
    localparam logic        [15:0]     TIMEOUT_V = 16'(TIMEOUT_CYC);

    for (genvar i = 0; i < CH; i++) begin : g_ch
        state_t                state_q, state_d;
        logic [W-1:0]          level_q, level_d;
        logic                  refill_req_q, refill_req_d;
        logic [15:0]           timer_q, timer_d;
        logic                  underflow_q, underflow_d;
        logic                  fault_q, fault_d;
        logic                  ack_eff;
        logic signed [NW-1:0]  net;

        always_comb begin
            // NOTE: every output of this block gets a default first, so no path can infer a latch.
            state_d      = state_q;
            level_d      = level_q;
            refill_req_d = refill_req_q;
            timer_d      = timer_q;
            underflow_d  = underflow_q;
            fault_d      = fault_q;

            ack_eff = refill_ack[i] && (state_q == ST_REQ);
            net     = $signed({2'b00, level_q});
            if (ack_eff)       net = net + QTY_S;
            if (add_manual[i]) net = net + ONE_S;
            if (dec[i])        net = net - ONE_S;

            if (net[NW-1])       level_d = '0;
            else if (net > MAX_S) level_d = W'(MAX_LVL);
            else                  level_d = net[W-1:0];

            if (dec[i] && !add_manual[i] && !ack_eff && level_q == '0)
                underflow_d = 1'b1;

            case (state_q)
                ST_NORMAL: begin
                    if (level_q <= W'(MIN_LVL)) begin
                        state_d      = ST_REQ;
                        refill_req_d = 1'b1;
                        timer_d      = '0;
                    end
                end
                ST_REQ: begin
                    if (ack_eff) begin
                        state_d      = ST_HOLD;
                        refill_req_d = 1'b0;
                        timer_d      = '0;
                    end else if (timer_q != TIMEOUT_V) begin
                        timer_d = timer_q + 16'd1;
                        if (timer_q == TIMEOUT_V - 16'd1) fault_d = 1'b1;
                    end
                end
                ST_HOLD:  state_d = ST_NORMAL;
                default:  state_d = ST_NORMAL;
            endcase

            // Reload wins over everything else in the same cycle; sticky flags are kept.
            if (start_proc) begin
                state_d      = ST_NORMAL;
                level_d      = W'(INIT_LVL);
                refill_req_d = 1'b0;
                timer_d      = '0;
                underflow_d  = underflow_q;
                fault_d      = fault_q;
            end
        end

        // NOTE: state registers use non-blocking assignments so all flops update from pre-edge values.
        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                state_q      <= ST_NORMAL;
                level_q      <= W'(INIT_LVL);
                refill_req_q <= 1'b0;
                timer_q      <= '0;
                underflow_q  <= 1'b0;
                fault_q      <= 1'b0;
            end else begin
                state_q      <= state_d;
                level_q      <= level_d;
                refill_req_q <= refill_req_d;
                timer_q      <= timer_d;
                underflow_q  <= underflow_d;
                fault_q      <= fault_d;
            end
        end

        assign level[i*W +: W] = level_q;
        assign avail[i]        = (level_q != '0);
        assign refill_req[i]   = refill_req_q;
        assign underflow[i]    = underflow_q;
        assign fault[i]        = fault_q;

`ifdef MAGAZINE_STATS_EN
        logic [15:0] used_q, used_d;

        always_comb begin
            used_d = used_q;
            if (!start_proc && dec[i] && level_q != '0 && used_q != 16'hFFFF)
                used_d = used_q + 16'd1;
        end

        always_ff @(posedge clk or posedge reset) begin
            if (reset) used_q <= '0;
            else       used_q <= used_d;
        end

        assign used_total[i*16 +: 16] = used_q;
`else
        assign used_total[i*16 +: 16] = 16'd0;
`endif
    end

endmodule

// File: doc/insumo_magazine.md
INSUMO_MAGAZINE -- requirements
Module: insumo_magazine

Interface
REQ-001 Parameter CH, default 2: number of independent consumable channels (corks, labels, ...).
REQ-002 Parameter W, default 5: level counter width per channel.
REQ-003 Parameter MAX_LVL, default 31: saturation ceiling, at most 2^W-1.
REQ-004 Parameter INIT_LVL, default 16: level loaded on reset/start_proc.
REQ-005 Parameter MIN_LVL, default 5: refill request threshold (level <= MIN_LVL).
REQ-006 Parameter REFILL_QTY, default 15: units added per acknowledged refill.
REQ-007 Parameter TIMEOUT_CYC, default 1000: cycles allowed in REQ before fault; 16-bit timer.
REQ-008 clk  input  1  system clock, rising edge.
REQ-009 reset  input  1  asynchronous, active-high reset.
REQ-010 start_proc  input  1  synchronous reload of all channels to INIT_LVL.
REQ-011 dec  input  CH  per-channel consume pulse, one unit per cycle high.
REQ-012 add_manual  input  CH  per-channel manual add pulse, one unit per cycle high.
REQ-013 refill_ack  input  CH  refill unit acknowledge, valid only while matching refill_req is high.
REQ-014 level  output  CH*W  channel i level at bits [i*W +: W].
REQ-015 avail  output  CH  combinational, level != 0.
REQ-016 refill_req  output  CH  registered, high in state REQ.
REQ-017 underflow  output  CH  sticky: dec seen at level 0.
REQ-018 fault  output  CH  sticky: refill timeout.
REQ-019 used_total  output  CH*16  per-channel consumed-unit count (see Configuration).

Function
REQ-020 Each channel SHALL run an identical, independent FSM: NORMAL, REQ, HOLD.
REQ-021 NORMAL->REQ on the clock edge where the registered level <= MIN_LVL; refill_req rises that edge.
REQ-022 REQ->HOLD on refill_ack=1: level += REFILL_QTY, saturated at MAX_LVL; refill_req falls that edge.
REQ-023 HOLD->NORMAL unconditionally after one cycle; HOLD blocks re-triggering of REQ.
REQ-024 In REQ, timer increments each cycle; at TIMEOUT_CYC without ack, fault set, stay in REQ, timer halts.
REQ-025 dec with level>0 decrements by 1 in any state; dec at level 0 leaves level unchanged and sets underflow.
REQ-026 add_manual increments by 1 unless level=MAX_LVL (ignored, no flag).
REQ-027 dec and add_manual together: level unchanged, no flag, used_total still +1 if level>0.
REQ-028 refill_ack with dec/add same cycle: net = level + REFILL_QTY + add - dec, computed in W+2 bits, clamped to [0, MAX_LVL].
REQ-029 refill_ack outside REQ SHALL be ignored.
REQ-030 Level SHALL never wrap; all arithmetic uses widened intermediates.
REQ-031 start_proc: all levels to INIT_LVL, FSMs to NORMAL, refill_req/timer cleared; underflow/fault/used_total retained; overrides all same-cycle inputs.

Reset
REQ-032 Asserting reset SHALL immediately set level=INIT_LVL, state NORMAL, refill_req=0, underflow=0, fault=0, timer=0, used_total=0.
REQ-033 Reset mid-REQ SHALL drop refill_req asynchronously; ack during reset ignored.

Configuration
REQ-034 Macro MAGAZINE_STATS_EN defined: used_total[i] increments on each effective consume (dec with level>0), saturating at 65535.
REQ-035 MAGAZINE_STATS_EN undefined: no counters synthesised, used_total driven constant 0, port retained.

Verification
REQ-036 Reset, CH=2 defaults: level=16/16, avail=11, refill_req=00; 11 dec on ch0 -> level0=5, refill_req[0]=1 next edge.
REQ-037 In REQ at level 5, ack with dec same cycle -> level0=19, refill_req[0]=0, HOLD one cycle then NORMAL.
REQ-038 Level 20, ack -> level 31 (saturated); add_manual at 31 -> stays 31.
REQ-039 Level 0 via ack withheld, dec -> level 0, underflow[0]=1; withhold ack 1000 cycles -> fault[0]=1, refill_req[0] still 1.
REQ-040 Reset asserted mid-REQ -> refill_req clears without clock edge, level=16; start_proc mid-REQ -> level 16, underflow/fault retained.
REQ-041 With MAGAZINE_STATS_EN, 11 dec plus one dec+add pair on ch1 -> used_total[1]=12; without macro -> 0.
